// File: rtl/direct_mapped_cache_pkg.sv
// Shared address-split helpers and default configuration for the direct-mapped cache.
package direct_mapped_cache_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CACHE_SIZE = 16;

  function automatic int index_w(input int cache_size);
    return $clog2(cache_size);
  endfunction

  // A fully-indexed address leaves no tag bits; keep one constant-zero bit so widths stay legal.
  function automatic int tag_w(input int addr_width, input int cache_size);
    return (addr_width > index_w(cache_size)) ? addr_width - index_w(cache_size) : 1;
  endfunction

  typedef struct packed {
    logic                                                     valid;
    logic [tag_w(DEF_ADDR_WIDTH, DEF_CACHE_SIZE)-1:0]         tag;
    logic [DEF_DATA_WIDTH-1:0]                                data;
  } cache_line_t;

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data line storage: one synchronous write port, one combinational read port.
module cache_line_array
  import direct_mapped_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int INDEX_W    = index_w(DEF_CACHE_SIZE),
  parameter int TAG_W      = tag_w(DEF_ADDR_WIDTH, DEF_CACHE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [CACHE_SIZE-1:0] valid_q;
  logic [TAG_W-1:0]      tag_mem  [CACHE_SIZE];
  logic [DATA_WIDTH-1:0] data_mem [CACHE_SIZE];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (we && rst) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/direct_mapped_cache_memory.sv
// Direct-mapped cache: address split, tag compare, registered read outputs.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module direct_mapped_cache_memory
  import direct_mapped_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  mem_write,
  input  logic                  mem_read,
`ifdef CACHE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  hit
);

  localparam int INDEX_W = index_w(CACHE_SIZE);
  localparam int TAG_W   = tag_w(ADDR_WIDTH, CACHE_SIZE);

  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  lookup_hit;
  logic                  read_cycle;

  assign index      = addr[INDEX_W-1:0];
  assign tag        = TAG_W'(addr >> INDEX_W);
  assign lookup_hit = line_valid && (line_tag == tag);
  // A simultaneous write takes priority, so the read is dropped entirely.
  assign read_cycle = mem_read && !mem_write;

  cache_line_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .CACHE_SIZE (CACHE_SIZE),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .we       (mem_write),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (wr_data),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
      hit       <= 1'b0;
    end else if (read_cycle) begin
      hit       <= lookup_hit;
      read_data <= lookup_hit ? line_data : '0;
    end else begin
      hit <= 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (read_cycle) begin
      if (lookup_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_direct_mapped_cache_memory.sv
// Directed self-checking bench for direct_mapped_cache_memory (honours CACHE_STATS_EN).
module tb_direct_mapped_cache_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        hit;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  direct_mapped_cache_memory dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_data   (wr_data),
    .mem_write (mem_write),
    .mem_read  (mem_read),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .read_data (read_data),
    .hit       (hit)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = wr;
    mem_read  = rd;
    addr      = a;
    wr_data   = d;
    @(posedge clk);
    #1;
  endtask

  // Write (optionally with a simultaneous read): hit drops, read_data holds.
  task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d, input logic with_rd);
    drive(1'b1, with_rd, a, d);
    check({tag, ".hit"}, {31'd0, hit}, 32'd0);
    check({tag, ".rd"}, read_data, exp_rd);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic exp_hit, input logic [31:0] exp_data);
    drive(1'b0, 1'b1, a, 32'h0);
    if (exp_hit) exp_hits++; else exp_misses++;
    exp_rd = exp_hit ? exp_data : 32'h0;
    check({tag, ".hit"}, {31'd0, hit}, {31'd0, exp_hit});
    check({tag, ".rd"}, read_data, exp_rd);
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, ".hits"}, hit_count, exp_hits);
    check({tag, ".misses"}, miss_count, exp_misses);
`else
    if (tag.len() == 0) $display("empty stats tag");
`endif
  endtask

  initial begin
    rst = 1'b0; addr = '0; wr_data = '0; mem_write = 1'b0; mem_read = 1'b0;
    #3;
    check("reset.hit", {31'd0, hit}, 32'd0);
    check("reset.rd", read_data, 32'd0);
    check_stats("reset");
    @(negedge clk);
    rst = 1'b1;

    do_write("wr8", 8'd8, 32'h12345678, 1'b0);
    do_read("rd8", 8'd8, 1'b1, 32'h12345678);
    do_read("rd4_cold", 8'd4, 1'b0, 32'h0);
    do_write("wr8_ovr", 8'd8, 32'hDEADBEEF, 1'b0);
    do_read("rd8_ovr", 8'd8, 1'b1, 32'hDEADBEEF);

    drive(1'b0, 1'b0, 8'd8, 32'h0);
    check("idle.hit", {31'd0, hit}, 32'd0);
    check("idle.rd", read_data, exp_rd);

    do_write("wr24", 8'd24, 32'hCAFEF00D, 1'b0);
    do_read("rd8_evicted", 8'd8, 1'b0, 32'h0);
    do_read("rd24", 8'd24, 1'b1, 32'hCAFEF00D);
    do_read("rd24_again", 8'd24, 1'b1, 32'hCAFEF00D);

    do_write("rdwr3", 8'd3, 32'h000000A5, 1'b1);
    do_read("rd3", 8'd3, 1'b1, 32'h000000A5);

    do_write("wr255", 8'd255, 32'h11223344, 1'b0);
    do_read("rd255", 8'd255, 1'b1, 32'h11223344);
    do_read("rd15_tagdiff", 8'd15, 1'b0, 32'h0);
    do_read("rd0_cold", 8'd0, 1'b0, 32'h0);
    do_read("rd3_kept", 8'd3, 1'b1, 32'h000000A5);
    check_stats("pre_reset");

    // Write to addr 40 is in flight when reset lands mid-cycle; it must not take effect.
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; addr = 8'd40; wr_data = 32'h0BADF00D;
    #2;
    rst = 1'b0;
    #1;
    check("midreset.hit", {31'd0, hit}, 32'd0);
    check("midreset.rd", read_data, 32'd0);
    exp_hits = 0; exp_misses = 0; exp_rd = '0;
    check_stats("midreset");
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b1;

    do_read("post_rd8", 8'd8, 1'b0, 32'h0);
    do_read("post_rd40", 8'd40, 1'b0, 32'h0);
    do_read("post_rd3", 8'd3, 1'b0, 32'h0);
    do_write("post_wr40", 8'd40, 32'h5A5A5A5A, 1'b0);
    do_read("post_rd40b", 8'd40, 1'b1, 32'h5A5A5A5A);
    do_read("post_rd24", 8'd24, 1'b0, 32'h0);
    check_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
